// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } state_t;

  // Active-low column strobes indexed by column number.
  localparam logic [COL_W-1:0][COL_W-1:0] COL_STROBE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [1:0] lowest_low(input logic [ROW_W-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROW_W - 1; i >= 0; i--)
      if (!rows[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the pulled-up row inputs; idles high out of reset.
module row_sync #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, press/release debounce and a
// single-entry valid/ready key event with sticky overrun.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 27_000,
  parameter int DEBOUNCE_SAMPLES = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [ROW_W-1:0] row_n,
  output logic [COL_W-1:0] col_n,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overrun
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // Extra headroom so the count can sit at its terminal value.
  localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);

  logic [ROW_W-1:0] row_s;
  logic [SW-1:0]    slot_cnt;
  logic [DW-1:0]    db_cnt;
  logic [1:0]       col_idx, row_idx;
  state_t           state, state_nxt;
  logic             slot_end, any_low, cap_low, db_last;
  logic             rotate, capture, db_clr, db_inc, post;

  row_sync #(.W(ROW_W)) u_row_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .d        (row_n),
    .q        (row_s)
  );

  assign slot_end = (slot_cnt == SW'(SCAN_DIV - 1));
  assign any_low  = ~&row_s;
  assign cap_low  = ~row_s[row_idx];
  assign db_last  = (db_cnt == DW'(DEBOUNCE_SAMPLES - 1));
  assign col_n    = COL_STROBE[col_idx];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) slot_cnt <= '0;
    else            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_SCAN;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (slot_end) begin
      unique case (state)
        ST_SCAN:       if (any_low) state_nxt = ST_PRESS_DB;
        ST_PRESS_DB:   if (!cap_low) state_nxt = ST_SCAN;
                       else if (db_last) state_nxt = ST_HELD;
        ST_HELD:       if (!cap_low) state_nxt = ST_RELEASE_DB;
        ST_RELEASE_DB: if (cap_low) state_nxt = ST_HELD;
                       else if (db_last) state_nxt = ST_SCAN;
        default:       state_nxt = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    rotate   = 1'b0;
    capture  = 1'b0;
    db_clr   = 1'b0;
    db_inc   = 1'b0;
    post     = 1'b0;
    key_down = (state == ST_HELD) || (state == ST_RELEASE_DB);
    if (slot_end) begin
      unique case (state)
        ST_SCAN: begin
          rotate  = !any_low;
          capture = any_low;
          db_clr  = any_low;
        end
        ST_PRESS_DB: begin
          db_inc = cap_low;
          post   = cap_low && db_last;
        end
        ST_HELD:       db_clr = !cap_low;
        ST_RELEASE_DB: db_inc = !cap_low;
        default: ;
      endcase
    end
  end

  // Column stays frozen outside SCAN so the captured key keeps being driven.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      db_cnt  <= '0;
    end else begin
      if (rotate)  col_idx <= col_idx + 2'd1;
      if (capture) row_idx <= lowest_low(row_s);
      if (db_clr)
        db_cnt <= '0;
      else if (db_inc && db_cnt != DW'(DEBOUNCE_SAMPLES))
        db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else if (post) begin
      if (key_valid && !key_ready) begin
        overrun <= 1'b1;
      end else begin
        key_valid <= 1'b1;
        key_code  <= {row_idx, col_idx};
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized keypad bench: a simulated switch matrix drives row_n from col_n and
// a slot-level reference model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int M_IDLE = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  row_n = 4'hF;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        key_down;
  logic        overrun;
  logic [15:0] keys = '0;
  bit          chk_on = 1'b0;
  int          n_chk = 0, n_pass = 0;

  always #5 sys_clk = ~sys_clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SAMPLES(DS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_down (key_down),
    .overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Physical matrix: a pressed switch at (r,c) pulls row r low while column c is strobed.
  function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [3:0] cn);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~|(k[i*4 +: 4] & ~cn);
    return r;
  endfunction

  always @(negedge sys_clk) row_n <= rows_of(keys, col_n);

  // Reference model, advanced once per clock from the values seen just before the edge.
  int         m_tick = 0, m_col = 0, m_mode = M_IDLE, m_cnt = 0, m_row = 0, m_code = 0;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  bit         m_valid = 0, m_ovr = 0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_tick = 0; m_col = 0; m_mode = M_IDLE; m_cnt = 0; m_row = 0;
      m_code = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_valid = 0; m_ovr = 0;
    end else begin
      logic [3:0] samp;
      bit post;
      samp = m_s2;
      post = 0;
      if (m_tick == SD - 1) begin
        case (m_mode)
          M_IDLE:
            if (samp != 4'hF) begin
              for (int r = 3; r >= 0; r--) if (!samp[r]) m_row = r;
              m_mode = M_PRESS;
              m_cnt = 0;
            end else m_col = (m_col + 1) % 4;
          M_PRESS:
            if (!samp[m_row]) begin
              m_cnt++;
              if (m_cnt == DS) begin m_mode = M_HELD; post = 1; end
            end else m_mode = M_IDLE;
          M_HELD:
            if (samp[m_row]) begin m_cnt = 0; m_mode = M_REL; end
          default:
            if (samp[m_row]) begin
              m_cnt++;
              if (m_cnt == DS) m_mode = M_IDLE;
            end else m_mode = M_HELD;
        endcase
      end
      if (post) begin
        if (m_valid && !key_ready) m_ovr = 1;
        else begin m_valid = 1; m_code = m_row * 4 + m_col; end
      end else if (m_valid && key_ready) m_valid = 0;
      m_tick = (m_tick + 1) % SD;
      m_s2 = m_s1;
      m_s1 = row_n;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("col_n", col_n, 8'(4'hF ^ (4'h1 << m_col)));
      chk("key_valid", key_valid, m_valid);
      if (m_valid) chk("key_code", key_code, 8'(m_code));
      chk("key_down", key_down, m_mode >= M_HELD);
      chk("overrun", overrun, m_ovr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, col_n, 8'h0E);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_down"}, key_down, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int k, nseg, len, w;
    @(posedge sys_clk); #1;
    chk_on = 1;
    chk_reset("rst");
    cyc(3);
    sys_rst_n = 1;

    // idle rotation
    cyc(40);
    chk("idle_valid", key_valid, 0);

    // key 10 held, then consumed
    keys[10] = 1'b1;
    cyc(60);
    chk("k10_code", key_code, 8'd10);
    chk("k10_down", key_down, 1);
    key_ready = 1; cyc(2); key_ready = 0;
    chk("k10_clr", key_valid, 0);

    // short release bounce, then real release
    keys = '0; cyc(8);
    keys[10] = 1'b1; cyc(20);
    chk("bounce_down", key_down, 1);
    chk("bounce_noevt", key_valid, 0);
    keys = '0; cyc(40);
    chk("rel_down", key_down, 0);

    // two presses with consumer stalled
    keys[5] = 1'b1; cyc(40); keys = '0; cyc(40);
    keys[7] = 1'b1; cyc(40); keys = '0; cyc(40);
    chk("ovr_flag", overrun, 1);
    chk("ovr_code", key_code, 8'd5);
    key_ready = 1; cyc(2); key_ready = 0;

    // reset during press debounce
    keys[3] = 1'b1;
    w = 0;
    while (m_mode != M_PRESS && w < 200) begin cyc(1); w++; end
    chk("wait_press", w < 200, 1);
    sys_rst_n = 0; #1;
    chk_reset("mid_rst");
    cyc(2);
    keys = '0;
    sys_rst_n = 1;
    cyc(20);
    chk("mid_noevt", key_valid, 0);

    // randomized episodes with bounce, stalls and occasional resets
    repeat (60) begin
      k = $urandom_range(0, 15);
      nseg = $urandom_range(2, 6);
      for (int s = 0; s < nseg; s++) begin
        keys = '0;
        if (s % 2 == 0) begin
          keys[k] = 1'b1;
          if ($urandom_range(0, 4) == 0) keys[$urandom_range(0, 15)] = 1'b1;
        end
        len = $urandom_range(1, 24);
        for (int c = 0; c < len; c++) begin
          key_ready = ($urandom_range(0, 3) == 0);
          cyc(1);
        end
        if ($urandom_range(0, 40) == 0) begin
          sys_rst_n = 0; cyc(2); sys_rst_n = 1;
        end
      end
      keys = '0;
      key_ready = 1;
      cyc(40);
      key_ready = 0;
    end

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27_000, sys_clk cycles per column slot (1 ms at 27 MHz).
REQ-002 SHALL have parameter DEBOUNCE_SAMPLES, default 10, consecutive matching samples required to accept a press or release.
REQ-003 SHALL have port sys_clk  input  1  system clock, 27 MHz.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row_n  input  4  matrix rows, active-low, externally pulled up, asynchronous to sys_clk.
REQ-006 SHALL have port col_n  output  4  column strobes, active-low, one-hot-low.
REQ-007 SHALL have port key_valid  output  1  a debounced key event is pending.
REQ-008 SHALL have port key_code  output  4  pending key, row_idx*4 + col_idx.
REQ-009 SHALL have port key_ready  input  1  consumer accepts the event when key_valid && key_ready.
REQ-010 SHALL have port key_down  output  1  level, a debounced key is currently held.
REQ-011 SHALL have port overrun  output  1  sticky, a press was accepted while key_valid was still pending.

Function
REQ-012 SHALL synchronize row_n through two flip-flops before any use.
REQ-013 SHALL run a slot counter 0..SCAN_DIV-1 and take one sample of the synchronized rows at count SCAN_DIV-1 (the slot end).
REQ-014 SHALL rotate col_n 1110 -> 1101 -> 1011 -> 0111 -> 1110 at each slot end, in SCAN state only.
REQ-015 SHALL implement states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-016 SCAN: at a slot end with any sampled row low, SHALL capture col_idx = current column and row_idx = lowest-index low row, freeze col_n, clear the debounce count, and enter PRESS_DB.
REQ-017 PRESS_DB: at each slot end, captured row low -> count+1; captured row high -> return to SCAN, resume rotation from the frozen column.
REQ-018 PRESS_DB: when count reaches DEBOUNCE_SAMPLES, SHALL enter HELD, set key_down=1 and post the event in the same cycle.
REQ-019 Posting SHALL set key_valid=1 and key_code={row_idx,col_idx}; if key_valid was already 1 and not accepted that cycle, SHALL keep the old key_code and set overrun=1.
REQ-020 key_valid SHALL clear on the cycle after key_valid && key_ready; key_code SHALL be stable while key_valid=1.
REQ-021 HELD: at a slot end with the captured row high, SHALL clear the count and enter RELEASE_DB; other rows SHALL be ignored.
REQ-022 RELEASE_DB: captured row high -> count+1; captured row low -> return to HELD; at DEBOUNCE_SAMPLES, SHALL set key_down=0 and enter SCAN with rotation resumed.
REQ-023 overrun SHALL clear only on reset.
REQ-024 Counters SHALL be sized with $clog2 of their parameter and SHALL never wrap past their terminal value.

Reset
REQ-025 Reset SHALL give: state SCAN, col_n=4'b1110, slot and debounce counters 0, key_valid=0, key_code=0, key_down=0, overrun=0, synchronizer flops all 1.
REQ-026 Reset asserted mid-debounce or with an event pending SHALL discard the event without emitting it.

Structure
REQ-027 A shared package keypad_pkg SHALL hold the state enum, the column one-hot constants and the key_code width.
REQ-028 The two-flop synchronizer SHALL be a sub-module named row_sync (4 bits wide, reset to 1).

Verification (SCAN_DIV=4, DEBOUNCE_SAMPLES=3)
REQ-029 Idle rows 1111 -> col_n cycles 1110,1101,1011,0111 every 4 clocks; key_valid stays 0.
REQ-030 Row 2 held low whenever col_n=1011 -> key_valid with key_code=4'd10 after 3 more slot ends; key_down=1; key_ready=1 clears key_valid next cycle.
REQ-031 Row bounce (low for 2 samples, then high) -> no event; rotation resumes from the frozen column.
REQ-032 Two presses with key_ready=0 -> first key_code kept; overrun=1.
REQ-033 Key released for 2 samples, then low again -> key_down stays 1 with no new event; release for 3 samples -> key_down=0, state SCAN.
REQ-034 sys_rst_n pulsed low during PRESS_DB -> all outputs at reset values and no event emitted.
